// File: rtl/submodule_stream_arbiter.sv
// Round-robin arbiter that merges four submodule streams onto one AXI-Stream
// master. Each granted packet is a header beat carrying length and port index,
// followed by len_reg data beats passed straight through from the granted port.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no packet open; sample requests and pick the next port round-robin
// HEADER | present the header beat, wait for tready
// DATA   | pass granted port's beats through until len_reg beats are moved

module submodule_stream_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SUB    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SUB-1:0]            sub_valid,
    input  logic [NUM_SUB-1:0]            sub_in_progress,
    input  logic [NUM_SUB-1:0]            sub_last,
    input  logic [6*NUM_SUB-1:0]          sub_length,
    input  logic [DATA_WIDTH*NUM_SUB-1:0] sub_data,
    output logic [NUM_SUB-1:0]            sub_ready,
    output logic [DATA_WIDTH-1:0]         M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    output logic                          M_AXIS_tlast,
    input  logic                          M_AXIS_tready,
    output logic                          protocol_error,
    output logic [1:0]                    grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [5:0] len_reg;
    logic [5:0] beat_cnt;

    logic [1:0]            rr_grant;
    logic                  rr_found;
    logic                  granted_valid;
    logic                  granted_last;
    logic [DATA_WIDTH-1:0] granted_data;
    logic [5:0]            granted_len;
    logic                  final_beat;
    logic                  data_xfer;
    logic [DATA_WIDTH-1:0] header_word;

    // In-progress flags are observed by integrators only; the arbiter does not act on them.
    logic unused_inputs;
    assign unused_inputs = ^sub_in_progress;

    assign granted_valid = sub_valid[grant_idx];
    assign granted_last  = sub_last[grant_idx];
    assign granted_data  = sub_data[DATA_WIDTH*grant_idx +: DATA_WIDTH];
    assign granted_len   = sub_length[6*rr_grant +: 6];
    assign final_beat    = (beat_cnt == len_reg - 6'd1);
    assign data_xfer     = granted_valid & M_AXIS_tready;

    // Round-robin search: first requester after last_grant, wrapping back to last_grant itself.
    always_comb begin : rr_search
        logic [1:0] idx;
        idx      = '0;
        rr_grant = last_grant;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!rr_found && sub_valid[idx]) begin
                rr_grant = idx;
                rr_found = 1'b1;
            end
        end
    end

    // Header layout: length in [5:0], port in [9:8], 0xA marker in [15:12].
    always_comb begin
        header_word        = '0;
        header_word[5:0]   = len_reg;
        header_word[9:8]   = grant_idx;
        header_word[15:12] = 4'hA;
    end

    // Stream outputs are decoded from the registered state so reset clears them at once.
    always_comb begin
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tlast  = 1'b0;
        M_AXIS_tdata  = '0;
        sub_ready     = '0;
        case (state)
            S_HEADER: begin
                M_AXIS_tvalid = 1'b1;
                M_AXIS_tdata  = header_word;
                M_AXIS_tlast  = (len_reg == 6'd0);
            end
            S_DATA: begin
                M_AXIS_tvalid        = granted_valid;
                M_AXIS_tdata         = granted_data;
                M_AXIS_tlast         = final_beat;
                sub_ready[grant_idx] = M_AXIS_tready;
            end
            default: ;
        endcase
    end

    // Packet sequencing; length comes from len_reg, sub_last is only cross-checked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            last_grant     <= 2'd3;
            grant_idx      <= 2'd0;
            len_reg        <= 6'd0;
            beat_cnt       <= 6'd0;
            protocol_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|sub_valid) begin
                        grant_idx <= rr_grant;
                        len_reg   <= granted_len;
                        beat_cnt  <= 6'd0;
                        state     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (M_AXIS_tready) begin
                        if (len_reg == 6'd0) begin
                            last_grant <= grant_idx;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_xfer) begin
                        if (granted_last != final_beat) begin
                            protocol_error <= 1'b1;
                        end
                        if (final_beat) begin
                            last_grant <= grant_idx;
                            beat_cnt   <= 6'd0;
                            state      <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
